step_dec_seq: RTL

//  Parametrised registered N-to-2^N one-hot decoder with a built-in step counter, for the processor control path.

---
 rtl/gpp_dec_pkg.sv | 23 ++
 rtl/dec_onehot_msb.sv | 18 +
 rtl/step_dec_seq.sv | 90 +++++++++
 3 files changed

// File: rtl/gpp_dec_pkg.sv
// Shared definitions for the processor-control decoders: mode encodings and
// the MSB-first one-hot helper (code 0 lights the top bit).
package gpp_dec_pkg;

    localparam logic MODE_DECODE = 1'b0;
    localparam logic MODE_STEP   = 1'b1;

    localparam int ONEHOT_MAX_N = 8;

    // Bits above 2**n-1 stay zero; out-of-range codes give an all-zero result.
    function automatic logic [2**ONEHOT_MAX_N-1:0] onehot_msb(
        input logic [ONEHOT_MAX_N-1:0] sel,
        input int                      n
    );
        logic [2**ONEHOT_MAX_N-1:0] code;
        code = '0;
        if (int'(sel) <= (2**n - 1)) begin
            code[(2**n - 1) - int'(sel)] = 1'b1;
        end
        return code;
    endfunction

endpackage

// File: rtl/dec_onehot_msb.sv
// Combinational N-to-2^N decoder with enable, MSB-first: sel=0 drives the
// top output bit, sel=2**N-1 drives bit 0.
module dec_onehot_msb #(
    parameter int N = 3
) (
    input  logic [N-1:0]      sel,
    input  logic              en,
    output logic [2**N-1:0]   y
);

    genvar gi;
    generate
        for (gi = 0; gi < 2**N; gi++) begin : g_bit
            assign y[gi] = en && (sel == N'(2**N - 1 - gi));
        end
    endgenerate

endmodule

// File: rtl/step_dec_seq.sv
// Registered one-hot decoder with a built-in control-step counter. Decode mode
// captures w; step mode counts T0..T(LAST_STEP) with clear/load/step priority.
module step_dec_seq
    import gpp_dec_pkg::*;
#(
    parameter int N         = 3,
    parameter int LAST_STEP = 2**N - 1,
    parameter bit WRAP      = 1'b1
) (
    input  logic               Clock,
    input  logic               Resetn,
    input  logic               Mode,
    input  logic               En,
    input  logic [N-1:0]       w,
    input  logic               Clear,
    input  logic               Load,
    input  logic [N-1:0]       LdVal,
    input  logic               Step,
    output logic [2**N-1:0]    y,
    output logic [N-1:0]       Count,
    output logic               Last,
    output logic               Wrapped
);

    generate
        if (LAST_STEP > 2**N - 1 || LAST_STEP < 0) begin : g_bad_last_step
            $error("step_dec_seq: LAST_STEP must lie in 0..2**N-1");
        end
    endgenerate

    localparam logic [N-1:0] LAST_SEL = N'(LAST_STEP);

    logic [N-1:0]    sel_reg;
    logic [N-1:0]    sel_next;
    logic [2**N-1:0] y_reg;
    logic [2**N-1:0] y_next;
    logic            last_reg;
    logic            wrapped_reg;
    logic            wrap_hit;

    // Priority Clear > Load > Step > hold; decode mode simply follows w.
    // A sel left above LAST_STEP by a mode switch is treated like LAST_STEP
    // for the wrap/saturate decision.
    always_comb begin
        sel_next = sel_reg;
        if (Clear) begin
            sel_next = '0;
        end else if (Mode == MODE_DECODE) begin
            sel_next = w;
        end else if (Load) begin
            sel_next = (LdVal > LAST_SEL) ? LAST_SEL : LdVal;
        end else if (Step) begin
            if (sel_reg < LAST_SEL) begin
                sel_next = sel_reg + 1'b1;
            end else if (WRAP) begin
                sel_next = '0;
            end
        end
    end

    assign wrap_hit = (Mode == MODE_STEP) && Step && !Clear && !Load
                      && WRAP && (sel_reg == LAST_SEL);

    dec_onehot_msb #(.N(N)) u_dec (
        .sel (sel_next),
        .en  (En),
        .y   (y_next)
    );

    // y, Count and Last are all loaded from sel_next so they never skew.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            sel_reg     <= '0;
            y_reg       <= '0;
            last_reg    <= 1'b0;
            wrapped_reg <= 1'b0;
        end else begin
            sel_reg     <= sel_next;
            y_reg       <= y_next;
            last_reg    <= (Mode == MODE_STEP) && (sel_next == LAST_SEL);
            wrapped_reg <= wrap_hit;
        end
    end

    assign y       = y_reg;
    assign Count   = sel_reg;
    assign Last    = last_reg;
    assign Wrapped = wrapped_reg;

endmodule
